// File: rtl/nvlink_vc_framing_encoder.sv
// Multi-VC flit framer: round-robin arbitration over NUM_VC streams with per-VC credits and sequence IDs.
// Optional CRC-8 field in the flit MSBs when NVLFE_CRC_EN is defined.
module nvlink_vc_framing_encoder #(
    parameter int  PAYLOAD_W = 96,
    parameter int  COH_W     = 8,
    parameter int  SEQ_W     = 24,
    parameter int  NUM_VC    = 4,
    parameter int  CREDITS   = 8,
    localparam int VCID_W    = $clog2(NUM_VC),
`ifdef NVLFE_CRC_EN
    localparam int CRC_W     = 8,
`else
    localparam int CRC_W     = 0,
`endif
    localparam int FIELD_W   = VCID_W + COH_W + SEQ_W + PAYLOAD_W,
    localparam int FLIT_W    = CRC_W + FIELD_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_VC-1:0]             in_valid,
    output logic [NUM_VC-1:0]             in_ready,
    input  logic [NUM_VC*PAYLOAD_W-1:0]   in_payload,
    input  logic [NUM_VC*COH_W-1:0]       in_coh,
    input  logic [NUM_VC-1:0]             credit_return,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [FLIT_W-1:0]             out_flit,
    output logic                          credit_err
);

    localparam int              CNT_W      = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);

    logic [NUM_VC-1:0][CNT_W-1:0] credit_q, credit_d;
    logic [NUM_VC-1:0][SEQ_W-1:0] seq_q, seq_d;
    logic [VCID_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic                         out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]            out_flit_q, out_flit_d;
    logic                         credit_err_q, credit_err_d;

    logic                         load_en;
    logic                         transfer;
    logic [NUM_VC-1:0]            eligible;
    logic [NUM_VC-1:0]            grant;
    logic [VCID_W-1:0]            grant_idx;
    logic [VCID_W-1:0]            idx;
    logic [FIELD_W-1:0]           field;
    logic [FLIT_W-1:0]            flit_next;

    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            eligible[v] = in_valid[v] && (credit_q[v] != '0);
        end
    end

    // Scan from the far end back toward rr_ptr so the last hit is the first eligible VC at/after rr_ptr.
    // NOTE: combinational blocks use blocking assignments and assign every output a default first, so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        if (load_en) begin
            for (int i = NUM_VC - 1; i >= 0; i--) begin
                idx = VCID_W'((int'(rr_ptr_q) + i) % NUM_VC);
                if (eligible[idx]) begin
                    grant          = '0;
                    grant[idx]     = 1'b1;
                    grant_idx      = idx;
                end
            end
        end
    end

    assign transfer = |grant;
    assign in_ready = grant;

    assign field = {grant_idx,
                    in_coh[grant_idx*COH_W +: COH_W],
                    seq_q[grant_idx],
                    in_payload[grant_idx*PAYLOAD_W +: PAYLOAD_W]};

`ifdef NVLFE_CRC_EN
    // CRC-8, poly 0x07, init 0, MSB-first, no reflection or final XOR.
    function automatic logic [7:0] crc8(input logic [FIELD_W-1:0] d);
        logic [7:0] c;
        logic       fb;
        c = '0;
        for (int i = FIELD_W - 1; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    assign flit_next = {crc8(field), field};
`else
    assign flit_next = field;
`endif

    always_comb begin
        out_valid_d  = out_valid_q;
        out_flit_d   = out_flit_q;
        rr_ptr_d     = rr_ptr_q;
        seq_d        = seq_q;
        credit_d     = credit_q;
        credit_err_d = credit_err_q;

        if (transfer) begin
            out_valid_d = 1'b1;
            out_flit_d  = flit_next;
            rr_ptr_d    = VCID_W'((int'(grant_idx) + 1) % NUM_VC);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        for (int v = 0; v < NUM_VC; v++) begin
            if (grant[v]) begin
                seq_d[v] = seq_q[v] + SEQ_W'(1);
            end
            // A grant and a return in the same cycle cancel out.
            case ({grant[v], credit_return[v]})
                2'b10:   credit_d[v] = credit_q[v] - CNT_W'(1);
                2'b01: begin
                    if (credit_q[v] == CREDIT_MAX) credit_err_d = 1'b1;
                    else                           credit_d[v]  = credit_q[v] + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the per-VC arrays are small flop banks, so they are reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q     <= {NUM_VC{CREDIT_MAX}};
            seq_q        <= '0;
            rr_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_flit_q   <= '0;
            credit_err_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            seq_q        <= seq_d;
            rr_ptr_q     <= rr_ptr_d;
            out_valid_q  <= out_valid_d;
            out_flit_q   <= out_flit_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_flit   = out_flit_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_nvlink_vc_framing_encoder.sv
// Directed bench for nvlink_vc_framing_encoder (SEQ_W=4 so sequence wrap is reachable quickly).
// Builds with or without NVLFE_CRC_EN; expected CRC is computed by the bench's own model.
module tb_nvlink_vc_framing_encoder;

    localparam int PAYLOAD_W = 96;
    localparam int COH_W     = 8;
    localparam int SEQ_W     = 4;
    localparam int NUM_VC    = 4;
    localparam int CREDITS   = 8;
    localparam int VCID_W    = 2;
`ifdef NVLFE_CRC_EN
    localparam int CRC_W     = 8;
`else
    localparam int CRC_W     = 0;
`endif
    localparam int FIELD_W   = VCID_W + COH_W + SEQ_W + PAYLOAD_W;
    localparam int FLIT_W    = CRC_W + FIELD_W;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NUM_VC-1:0]           in_valid;
    logic [NUM_VC-1:0]           in_ready;
    logic [NUM_VC*PAYLOAD_W-1:0] in_payload;
    logic [NUM_VC*COH_W-1:0]     in_coh;
    logic [NUM_VC-1:0]           credit_return;
    logic                        out_valid;
    logic                        out_ready;
    logic [FLIT_W-1:0]           out_flit;
    logic                        credit_err;

    logic [PAYLOAD_W-1:0] pay [NUM_VC];
    logic [COH_W-1:0]     coh [NUM_VC];

    int checks = 0;
    int errors = 0;

    nvlink_vc_framing_encoder #(
        .PAYLOAD_W(PAYLOAD_W), .COH_W(COH_W), .SEQ_W(SEQ_W),
        .NUM_VC(NUM_VC), .CREDITS(CREDITS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_payload(in_payload), .in_coh(in_coh),
        .credit_return(credit_return),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_flit(out_flit), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            in_payload[v*PAYLOAD_W +: PAYLOAD_W] = pay[v];
            in_coh[v*COH_W +: COH_W]             = coh[v];
        end
    end

    task automatic check(input string name, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

`ifdef NVLFE_CRC_EN
    function automatic logic [7:0] crc8(input logic [FIELD_W-1:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = FIELD_W - 1; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    function automatic logic [FLIT_W-1:0] exp_flit(input int vc, input int seq);
        logic [FIELD_W-1:0] f;
        f = {VCID_W'(vc), coh[vc], SEQ_W'(seq), pay[vc]};
`ifdef NVLFE_CRC_EN
        return {crc8(f), f};
`else
        return f;
`endif
    endfunction

    typedef struct {
        logic [NUM_VC-1:0] iv;
        logic [NUM_VC-1:0] cr;
        logic              ordy;
        logic [NUM_VC-1:0] rdy;
        logic              ov;
        int                vc;
        int                seq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] iv, input logic [3:0] cr, input logic ordy,
                       input logic [3:0] rdy, input logic ov, input int vc, input int seq);
        vec_t t;
        t = '{iv, cr, ordy, rdy, ov, vc, seq};
        vecs.push_back(t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = '0;
        credit_return = '0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        for (int v = 0; v < NUM_VC; v++) begin
            pay[v] = {12{8'hA5 + 8'(v)}};
            coh[v] = 8'h3C + 8'(v);
        end
        rst_n = 1'b0;
        in_valid = '0;
        credit_return = '0;
        out_ready = 1'b1;

        //   iv       cr       ordy  rdy      ov  vc seq
        add(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 0, 0);  // first flit
        add(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 1, 0);  // round robin
        add(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2, 0);
        add(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 3, 0);
        add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 0, 1);
        add(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 1, 1);
        for (int k = 0; k < 5; k++)                         // stall holds flit
            add(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 1, 1);
        add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0);
        for (int k = 0; k < 6; k++)                         // drain VC1 credits
            add(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1, 2 + k);
        add(4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0);  // masked
        add(4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b0, 0, 0);  // return does not unmask same cycle
        add(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1, 8);
        add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0);
        add(4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 2, 1);  // rr_ptr=2
        add(4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 0, 2);  // wraps past 3
        add(4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 2, 2);
        add(4'b1010, 4'b0000, 1'b1, 4'b1000, 1'b1, 3, 1);  // VC1 starved of credit
        add(4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_flit", out_flit, 0);
        check("reset credit_err", credit_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid = vecs[i].iv;
            credit_return = vecs[i].cr;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d in_ready", i), in_ready, vecs[i].rdy);
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), out_valid, vecs[i].ov);
            if (vecs[i].ov) check($sformatf("v%0d out_flit", i), out_flit, exp_flit(vecs[i].vc, vecs[i].seq));
        end
        check("table credit_err", credit_err, 0);

        // Reset with a flit stalled in the output register discards it.
        @(negedge clk);
        in_valid = 4'b0001;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre-reset out_valid", out_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = '0;
        #1;
        check("midreset out_valid", out_valid, 0);
        check("midreset out_flit", out_flit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // VC1 alone from reset: exactly CREDITS flits, then one return buys one more.
        n = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            in_valid = 4'b0010;
            #1;
            if (in_ready[1]) n++;
        end
        check("vc1 grants from reset", n, 8);
        @(negedge clk);
        credit_return = 4'b0010;
        #1;
        check("vc1 masked with return", in_ready, 4'b0000);
        @(negedge clk);
        credit_return = 4'b0000;
        #1;
        check("vc1 after return", in_ready, 4'b0010);
        @(posedge clk);
        #1;
        check("vc1 extra flit", out_flit, exp_flit(1, 8));
        @(negedge clk);
        #1;
        check("vc1 exhausted again", in_ready, 4'b0000);

        // Sequence wrap on VC2; grant+return each cycle keeps credits full without error.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            in_valid = 4'b0100;
            credit_return = 4'b0100;
            @(posedge clk);
            #1;
            check($sformatf("vc2 seq %0d", k), out_flit, exp_flit(2, k % 16));
        end
        check("wrap credit_err", credit_err, 0);

        // Return at full credit: sticky error, credit stays at CREDITS.
        do_reset();
        @(negedge clk);
        credit_return = 4'b0001;
        @(posedge clk);
        #1;
        check("overflow credit_err", credit_err, 1);
        @(negedge clk);
        credit_return = 4'b0000;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 4'b0001;
            #1;
            if (in_ready[0]) n++;
        end
        check("vc0 credits after overflow", n, 8);
        check("credit_err sticky", credit_err, 1);

`ifdef NVLFE_CRC_EN
        do_reset();
        pay[0] = '0;
        coh[0] = '0;
        @(negedge clk);
        in_valid = 4'b0001;
        @(posedge clk);
        #1;
        check("zero field crc", out_flit[FLIT_W-1 -: 8], 8'h00);
        check("zero field flit", out_flit, 0);
`endif

        @(negedge clk);
        in_valid = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
